// File: rtl/edge_window_generator_pkg.sv
// Shared constants and types for the 3x3 neighbourhood interface.
package edge_window_generator_pkg;

  // Default pixel width and frame geometry.
  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_IMG_WIDTH  = 512;
  localparam int unsigned DEF_IMG_HEIGHT = 512;

  // Window positions, 1-based row-major; p5 is the centre.
  localparam int unsigned WIN_SIZE     = 9;
  localparam int unsigned TOP_LEFT     = 1;
  localparam int unsigned CENTRE       = 5;
  localparam int unsigned BOTTOM_RIGHT = 9;

  // Edge-class encodings shared with the downstream classifier.
  typedef enum logic [1:0] {
    NO_EDGE                  = 2'd0,
    VERTICAL_HORIZONTAL_EDGE = 2'd1,
    DIAGONAL_EDGE            = 2'd2
  } edge_class_e;

endpackage

// File: rtl/edge_window_generator_line_buffer_ram.sv
// Simple dual-port line buffer with combinational read and synchronous write.
// Reading and writing the same address in one cycle returns the old contents.
module line_buffer_ram #(
  parameter int unsigned Depth = 512,
  parameter int unsigned Width = 8,
  localparam int unsigned Aw   = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [Aw-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Aw-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem [Depth];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/edge_window_generator.sv
// Streaming 3x3 window generator: raster pixels in, interior neighbourhoods out.
module edge_window_generator
  import edge_window_generator_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int unsigned DATA_W     = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pixel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] p1,
  output logic [DATA_W-1:0] p2,
  output logic [DATA_W-1:0] p3,
  output logic [DATA_W-1:0] p4,
  output logic [DATA_W-1:0] p5,
  output logic [DATA_W-1:0] p6,
  output logic [DATA_W-1:0] p7,
  output logic [DATA_W-1:0] p8,
  output logic [DATA_W-1:0] p9,
  output logic              out_last,
  output logic              frame_done
);

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              frame_done_q, frame_done_d;
  logic [DATA_W-1:0] win_q [WIN_SIZE];
  logic [DATA_W-1:0] win_d [WIN_SIZE];

  logic              accept, col_end, row_end, qualify;
  logic [DATA_W-1:0] lb0_rdata, lb1_rdata;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_end  = (col_q == CW'(IMG_WIDTH - 1));
  assign row_end  = (row_q == RW'(IMG_HEIGHT - 1));
  assign qualify  = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

  // lb0 holds row r-1, lb1 holds row r-2; lb1 is refilled from lb0's old word.
  line_buffer_ram #(
    .Depth (IMG_WIDTH),
    .Width (DATA_W)
  ) u_lb0 (
    .clk_i   (clk),
    .we_i    (accept),
    .waddr_i (col_q),
    .wdata_i (in_pixel),
    .raddr_i (col_q),
    .rdata_o (lb0_rdata)
  );

  line_buffer_ram #(
    .Depth (IMG_WIDTH),
    .Width (DATA_W)
  ) u_lb1 (
    .clk_i   (clk),
    .we_i    (accept),
    .waddr_i (col_q),
    .wdata_i (lb0_rdata),
    .raddr_i (col_q),
    .rdata_o (lb1_rdata)
  );

  // Raster position, window shift and output handshake next-state.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    frame_done_d = accept && col_end && row_end;

    if (accept) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      // Shift every row left by one column; new right column comes from the buffers.
      for (int i = 0; i < 3; i++) begin
        win_d[3*i]     = win_q[3*i + 1];
        win_d[3*i + 1] = win_q[3*i + 2];
      end
      win_d[2] = lb1_rdata;
      win_d[5] = lb0_rdata;
      win_d[8] = in_pixel;
    end

    if (qualify) begin
      out_valid_d = 1'b1;
      out_last_d  = col_end && row_end;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      win_q        <= '{default: '0};
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;
  assign p1 = win_q[TOP_LEFT - 1];
  assign p2 = win_q[1];
  assign p3 = win_q[2];
  assign p4 = win_q[3];
  assign p5 = win_q[CENTRE - 1];
  assign p6 = win_q[5];
  assign p7 = win_q[6];
  assign p8 = win_q[7];
  assign p9 = win_q[BOTTOM_RIGHT - 1];

endmodule

// File: tb/tb_edge_window_generator.sv
// Randomised bench for edge_window_generator on a 5x4 frame, checked against an image-level model.
module tb_edge_window_generator;

  localparam int W = 5;
  localparam int H = 4;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_pixel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic       out_last;
  logic       frame_done;

  always #5 clk = ~clk;

  edge_window_generator #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .DATA_W     (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .p1         (p1),
    .p2         (p2),
    .p3         (p3),
    .p4         (p4),
    .p5         (p5),
    .p6         (p6),
    .p7         (p7),
    .p8         (p8),
    .p9         (p9),
    .out_last   (out_last),
    .frame_done (frame_done)
  );

  logic [71:0] dut_win;
  assign dut_win = {p1, p2, p3, p4, p5, p6, p7, p8, p9};

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Image-level reference: pixels land in img[row][col] by arrival order.
  logic [7:0]  img [H][W];
  bit          model_on = 1'b0;
  bit          exp_valid, exp_last, exp_fd;
  logic [71:0] exp_win;
  int          n;
  int          m_r, m_c;
  bit          m_acc;

  // Observed handshakes, reset per scenario by the main sequence.
  logic [71:0] got_q [$];
  bit          last_q [$];
  int          fd_count;

  always @(negedge clk) begin
    if (model_on) begin
      chk("out_valid", {71'd0, out_valid}, {71'd0, exp_valid});
      chk("in_ready", {71'd0, in_ready}, {71'd0, (!exp_valid || out_ready)});
      chk("frame_done", {71'd0, frame_done}, {71'd0, exp_fd});
      if (exp_valid) begin
        chk("window", dut_win, exp_win);
        chk("out_last", {71'd0, out_last}, {71'd0, exp_last});
      end
      if (out_valid && out_ready) begin
        got_q.push_back(dut_win);
        last_q.push_back(out_last);
      end
      if (frame_done) fd_count++;
    end

    if (!rst_n) begin
      model_on  = 1'b1;
      exp_valid = 1'b0;
      exp_last  = 1'b0;
      exp_fd    = 1'b0;
      n         = 0;
    end else if (model_on) begin
      m_acc  = in_valid && (!exp_valid || out_ready);
      exp_fd = m_acc && (n == N - 1);
      if (m_acc) begin
        m_r = n / W;
        m_c = n % W;
        img[m_r][m_c] = in_pixel;
        if (m_r >= 2 && m_c >= 2) begin
          exp_valid = 1'b1;
          exp_last  = (n == N - 1);
          exp_win   = {img[m_r-2][m_c-2], img[m_r-2][m_c-1], img[m_r-2][m_c],
                       img[m_r-1][m_c-2], img[m_r-1][m_c-1], img[m_r-1][m_c],
                       img[m_r][m_c-2],   img[m_r][m_c-1],   img[m_r][m_c]};
        end else if (out_ready) begin
          exp_valid = 1'b0;
          exp_last  = 1'b0;
        end
        n = (n + 1) % N;
      end else if (out_ready) begin
        exp_valid = 1'b0;
        exp_last  = 1'b0;
      end
    end
  end

  // Downstream ready: steady, random, or a one-shot 3-cycle stall on the window centred 0x12.
  bit rdy_rand    = 1'b0;
  bit stall_armed = 1'b0;
  bit stall_hit   = 1'b0;
  int stall_left  = 0;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (stall_armed && out_valid && p5 == 8'h12) begin
        out_ready   = 1'b0;
        stall_left  = 2;
        stall_armed = 1'b0;
        stall_hit   = 1'b1;
      end else begin
        out_ready = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
      end
    end
  end

  // Feeds one frame; stops early after accepting pixel index abort_idx.
  task automatic feed_frame(input logic [7:0] base, input bit edge_pat, input int vpct,
                            input int abort_idx);
    int idx = 0;
    int cyc = 0;
    bit stop = 1'b0;
    while (idx < N && !stop && cyc < 500) begin
      @(posedge clk);
      #1;
      in_valid = ($urandom_range(99) < vpct);
      if (edge_pat) in_pixel = (idx / W == 0) ? 8'h00 : 8'hFF;
      else          in_pixel = 8'(base + (idx / W) * 16 + (idx % W));
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (idx == abort_idx) stop = 1'b1;
        idx++;
      end
      cyc++;
    end
    if (cyc >= 500) begin
      checks++;
      failures++;
      $display("FAIL feed_timeout: accepted %0d of %0d pixels", idx, N);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    rdy_rand = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    got_q.delete();
    last_q.delete();
    fd_count = 0;
  endtask

  task automatic chk_cleared(input string name);
    @(negedge clk);
    chk({name, "_window"}, dut_win, 72'd0);
    chk({name, "_out_valid"}, {71'd0, out_valid}, 72'd0);
    chk({name, "_out_last"}, {71'd0, out_last}, 72'd0);
    chk({name, "_frame_done"}, {71'd0, frame_done}, 72'd0);
  endtask

  localparam logic [71:0] FirstWin = 72'h00_01_02_10_11_12_20_21_22;

  logic [71:0] ref_q [$];
  int          idx12, hi_cnt, bad_mix, last_sum;
  logic [71:0] w;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_pixel = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_cleared("reset");
    chk("reset_in_ready", {71'd0, in_ready}, 72'd1);

    // Continuous stream, always ready.
    clear_obs();
    feed_frame(8'h00, 1'b0, 100, -1);
    drain();
    chk("s1_count", 72'(got_q.size()), 72'd6);
    if (got_q.size() == 6) begin
      chk("s1_first", got_q[0], FirstWin);
      chk("s1_last_p5", {64'd0, got_q[5][39:32]}, 72'h23);
      chk("s1_last_flag", {71'd0, last_q[5]}, 72'd1);
    end
    last_sum = 0;
    foreach (last_q[i]) last_sum += int'(last_q[i]);
    chk("s1_last_once", 72'(last_sum), 72'd1);
    chk("s1_frame_done", 72'(fd_count), 72'd1);
    ref_q = got_q;

    // Stall while the window centred 0x12 is presented.
    clear_obs();
    stall_hit   = 1'b0;
    stall_armed = 1'b1;
    feed_frame(8'h00, 1'b0, 100, -1);
    drain();
    chk("s2_stall_hit", {71'd0, stall_hit}, 72'd1);
    chk("s2_count", 72'(got_q.size()), 72'd6);
    idx12 = -1;
    foreach (got_q[i]) if (got_q[i][39:32] == 8'h12) idx12 = i;
    if (idx12 >= 0 && idx12 + 1 < got_q.size()) chk("s2_next_p5", {64'd0, got_q[idx12+1][39:32]}, 72'h13);
    else chk("s2_found_12", 72'(idx12), 72'd1);

    // Random input gaps, then random gaps with random downstream ready.
    for (int pass = 0; pass < 2; pass++) begin
      clear_obs();
      rdy_rand = (pass == 1);
      feed_frame(8'h00, 1'b0, 50, -1);
      drain();
      chk("s3_count", 72'(got_q.size()), 72'd6);
      if (got_q.size() == 6) foreach (ref_q[i]) chk("s3_window", got_q[i], ref_q[i]);
      chk("s3_frame_done", 72'(fd_count), 72'd1);
    end

    // Two back-to-back frames with distinct pixel ranges.
    clear_obs();
    feed_frame(8'h00, 1'b0, 100, -1);
    feed_frame(8'h80, 1'b0, 100, -1);
    drain();
    chk("s4_count", 72'(got_q.size()), 72'd12);
    if (got_q.size() == 12) chk("s4_f2_first_p5", {64'd0, got_q[6][39:32]}, 72'h91);
    bad_mix = 0;
    foreach (got_q[i]) begin
      w = got_q[i];
      hi_cnt = 0;
      for (int b = 0; b < 9; b++) hi_cnt += int'(w[8*b+7]);
      if (hi_cnt != 0 && hi_cnt != 9) bad_mix++;
    end
    chk("s4_cross_frame", 72'(bad_mix), 72'd0);
    chk("s4_frame_done", 72'(fd_count), 72'd2);

    // Reset mid-frame after accepting 0x13, then restart.
    clear_obs();
    feed_frame(8'h00, 1'b0, 100, 8);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_cleared("s5_reset");
    clear_obs();
    feed_frame(8'h00, 1'b0, 100, -1);
    drain();
    chk("s5_count", 72'(got_q.size()), 72'd6);
    if (got_q.size() > 0) chk("s5_first", got_q[0], FirstWin);

    // Horizontal step between row 0 and the rest.
    clear_obs();
    feed_frame(8'h00, 1'b1, 100, -1);
    drain();
    if (got_q.size() > 0) chk("s6_first", got_q[0], 72'h00_00_00_FF_FF_FF_FF_FF_FF);
    else chk("s6_count", 72'(got_q.size()), 72'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/edge_window_generator.md
Name: edge_window_generator

Overview:
- Streaming 3x3 window generator. Accepts one 8-bit grayscale/channel pixel per handshake in raster order and emits fully-populated interior 3x3 neighbourhoods.
- Producing side of the neighbourhood interface read by the edge-detection classifier and the transmission-estimation filters. Outputs p1..p9 map directly onto their pixel inputs, with p5 as centre.
- Owns line buffering, row/column tracking, frame boundaries and backpressure, so downstream classifiers stay purely combinational.

Parameters:
- IMG_WIDTH, 512: pixels per row; must be >= 3.
- IMG_HEIGHT, 512: rows per frame; must be >= 3.
- DATA_W, 8: pixel width in bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  in_pixel valid
- in_ready  out  1  block accepts in_pixel this cycle
- in_pixel  in  DATA_W  raster-order pixel
- out_valid  out  1  window valid
- out_ready  in  1  downstream accepts window
- p1..p9  out  DATA_W each  window, row-major; p1 top-left, p5 centre, p9 bottom-right
- out_last  out  1  final window of frame, qualified by out_valid
- frame_done  out  1  one-cycle pulse when last input pixel of frame is accepted

Behaviour:
- Reset: rst_n sampled on the clk edge.
  - Cleared: col/row counters, out_valid, out_last, frame_done, p1..p9, window registers.
  - Line-buffer RAM contents are not cleared.
- Accept: accept = in_valid && in_ready. in_ready = !out_valid || out_ready (single output register stage, full throughput).
- Counters:
  - col increments per accept; at IMG_WIDTH-1 it wraps to 0 and row increments.
  - At row IMG_HEIGHT-1, col IMG_WIDTH-1: both wrap to 0 and frame_done pulses the next cycle.
- Line buffers: two RAMs, depth IMG_WIDTH.
  - On accept at column c: read lb0[c] (row r-1) and lb1[c] (row r-2).
  - Then write lb1[c] <= lb0[c] and lb0[c] <= in_pixel. Read-before-write at the same address is required.
- Window shift: on accept, the three window columns shift left. The new right column is {lb1[c], lb0[c], in_pixel} → {p3, p6, p9}.
- Emission:
  - The accept at (r, c) with r >= 2 and c >= 2 sets out_valid on the next edge, with the window centred at (r-1, c-1).
  - Otherwise, if out_ready, out_valid clears.
  - Columns 0..1 and rows 0..1 produce no output.
  - Output count per frame is (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Latency: 1 cycle from the qualifying accept to out_valid.
- Hold: while out_valid && !out_ready, p1..p9 and out_last stay stable and in_ready = 0.
- Simultaneous events:
  - If out_ready and a qualifying accept occur in the same cycle, the new window replaces the old with no bubble.
  - frame_done and the next frame's first accept may coincide.
- Row wrap: window registers are not cleared at row start. Stale columns are shifted out before c = 2, so no special handling is needed.
- out_last = 1 only for the window from the accept at (IMG_HEIGHT-1, IMG_WIDTH-1).
- Reset mid-frame: the next accepted pixel is treated as (0, 0). No window is emitted until rows 0..1 are refilled.
- Arithmetic: counters are $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT) bits, unsigned. No pixel arithmetic.

Decomposition:
- Shared package holds:
  - DATA_W
  - default IMG_WIDTH/IMG_HEIGHT
  - window index constants (CENTRE = 5)
  - the edge-class encodings NO_EDGE = 0, VERTICAL_HORIZONTAL_EDGE = 1, DIAGONAL_EDGE = 2, shared with the classifier.
- One sub-module: line_buffer_ram.
  - Simple dual-port, depth IMG_WIDTH, width DATA_W.
  - Combinational or registered read, chosen to meet the read-before-write rule.
  - Instantiated twice.

Test Plan (IMG_WIDTH=5, IMG_HEIGHT=4, pixel = row*16 + col):
1. Continuous stream, out_ready = 1: first out_valid 1 cycle after accepting 0x22, with p1..p9 = 00,01,02,10,11,12,20,21,22. Exactly 6 windows; last has p5 = 0x23 and out_last = 1. frame_done pulses once.
2. Hold out_ready = 0 for 3 cycles while the window centred 0x12 is valid: p1..p9 stable, in_ready = 0, no pixels lost. The next window is centred 0x13.
3. Toggle in_valid randomly (50%): window contents and count identical to scenario 1.
4. Two back-to-back frames, second pixel = 0x80 + row*16 + col: second frame's first window has p5 = 0x91, with no cross-frame data in any window.
5. Assert rst_n = 0 for 1 cycle after accepting 0x13, then restart the frame: outputs cleared the cycle after reset. First window after restart equals scenario 1's first window.
6. Feed a frame whose row 0 is 0x00 and rows 1+ are 0xFF, through edge_window_generator into the classifier: the window centred at (1, 1) gives ED_out = VERTICAL_HORIZONTAL_EDGE.
